// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : btn_conditioner
//  Purpose  : Conditions raw push-button pins for the animation/speed control.
//             For each channel it produces a synchronised, debounced level, a
//             one-cycle press pulse, a one-cycle release pulse and, when built
//             with BTN_AUTOREPEAT_EN defined, one-cycle auto-repeat pulses
//             while the button is held.
//  Ports    : clk          system clock
//             reset        synchronous active-high reset
//             btn_raw      asynchronous raw pins, 1 = pressed
//             btn_level    debounced level
//             btn_press    pulse on debounced 0->1
//             btn_release  pulse on debounced 1->0
//             btn_repeat   auto-repeat pulse while held (0 without the macro)
//             btn_any      OR of btn_press and btn_repeat over all channels
//  Options  : `define BTN_AUTOREPEAT_EN to build the hold counters.
//  Revision : 1.0  initial release
// ============================================================================
module btn_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 512,
  parameter int CNT_W           = 24,
  parameter int REPEAT_DELAY    = 5_000_000,
  parameter int REPEAT_PERIOD   = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic               btn_any
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  // Encoding chosen so that bit 1 is the debounced level.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DEB_ON  = 2'd1,
    ST_HELD    = 2'd2,
    ST_DEB_OFF = 2'd3
  } state_t;

  // Elaboration-time sanity check of the configuration.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD >= REPEAT_DELAY ||
      CNT_W < 1 || CNT_W > 62 || longint'(REPEAT_DELAY) >= (64'sd1 <<< CNT_W)) begin : g_param_check
    $error("btn_conditioner: invalid parameter set");
  end

  // Two-flop synchroniser for the asynchronous pins.
  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    state_t           state_q;
    logic [DEB_W-1:0] deb_q;
    logic [DEB_W-1:0] deb_d;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             w_lvl;
    logic             w_mis;
    logic             w_thr;

    assign w_lvl = state_q[1];
    assign w_mis = (sync2_q[i] != w_lvl);
    // Threshold reached: the level flips at this edge and the counter clears.
    assign w_thr = w_mis && (deb_q == DEB_LAST);
    assign deb_d = (!w_mis || w_thr) ? '0 : deb_q + 1'b1;

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q   <= ST_IDLE;
        deb_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        deb_q     <= deb_d;
        level_q   <= w_thr ? ~w_lvl : w_lvl;
        press_q   <= w_thr & ~w_lvl;
        release_q <= w_thr & w_lvl;
        case (state_q)
          ST_IDLE:    state_q <= sync2_q[i] ? ST_DEB_ON : ST_IDLE;
          ST_DEB_ON:  state_q <= w_thr ? ST_HELD : (sync2_q[i] ? ST_DEB_ON : ST_IDLE);
          ST_HELD:    state_q <= sync2_q[i] ? ST_HELD : ST_DEB_OFF;
          ST_DEB_OFF: state_q <= w_thr ? ST_IDLE : (sync2_q[i] ? ST_HELD : ST_DEB_OFF);
          default:    state_q <= ST_IDLE;
        endcase
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic [CNT_W-1:0] w_inc;
    logic             w_hit;
    logic             rpt_q;

    assign w_inc = hold_q + 1'b1;
    // Only count while held and not in the edge that produces a release
    // pulse, so no repeat can land on or after the release.
    assign w_hit = w_lvl && !w_thr && (w_inc == RPT_DELAY);

    // Cleared in the press-pulse cycle and whenever the level is low; the
    // reload keeps the counter below REPEAT_DELAY so it never wraps.
    always_comb begin
      hold_d = w_inc;
      if (!w_lvl || w_thr) begin
        hold_d = '0;
      end else if (w_hit) begin
        hold_d = RPT_RELOAD;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        hold_q <= '0;
        rpt_q  <= 1'b0;
      end else begin
        hold_q <= hold_d;
        rpt_q  <= w_hit;
      end
    end

    assign btn_repeat[i] = rpt_q;
`else
    assign btn_repeat[i] = 1'b0;
`endif
  end

  assign btn_any = |(btn_press | btn_repeat);

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_conditioner
//  Purpose  : Directed self-checking bench for btn_conditioner with
//             DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, NUM_BTN=4.
//             Edge numbers below count rising clock edges from time zero;
//             inputs change just after an edge, outputs are read 1 ns after.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] btn_repeat;
  logic       btn_any;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  btn_conditioner #(
    .NUM_BTN         (4),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (24),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat),
    .btn_any     (btn_any)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
  endtask

  task automatic goto(input int k);
    while (edge_n < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    goto(2);
    check("rst_level", btn_level, 4'b0000);
    check("rst_press", btn_press, 4'b0000);
    check("rst_release", btn_release, 4'b0000);
    check("rst_repeat", btn_repeat, 4'b0000);
    check("rst_any", btn_any, 1'b0);
    goto(3);
    reset = 1'b0;

    // 1. Clean press on channel 0: driven after edge 10, level at edge 16
    goto(10);
    btn_raw[0] = 1'b1;
    goto(15);
    check("t1_level_early", btn_level, 4'b0000);
    check("t1_press_early", btn_press, 4'b0000);
    goto(16);
    check("t1_level", btn_level, 4'b0001);
    check("t1_press", btn_press, 4'b0001);
    check("t1_any", btn_any, 1'b1);
    goto(17);
    check("t1_press_end", btn_press, 4'b0000);
    check("t1_level_hold", btn_level, 4'b0001);

    // 2. Bounce on channel 1: 1,0,1,0 every 2 cycles, settles at 1 after edge 28
    for (int e = 20; e <= 33; e++) begin
      goto(e);
      check("t2_bounce_level", btn_level[1], 1'b0);
      check("t2_bounce_press", btn_press[1], 1'b0);
      if (e == 20 || e == 24 || e == 28) btn_raw[1] = 1'b1;
      if (e == 22 || e == 26)            btn_raw[1] = 1'b0;
    end
    goto(34);
    check("t2_press", btn_press, 4'b0010);
    check("t2_level", btn_level, 4'b0011);
    goto(35);
    check("t2_press_end", btn_press[1], 1'b0);
    goto(36);
    btn_raw[1] = 1'b0;

    // 3. Release channel 0 after edge 40 (channel 1 released after edge 36)
    goto(40);
    btn_raw[0] = 1'b0;
    for (int e = 41; e <= 50; e++) begin
      goto(e);
      check("t3_no_press", btn_press, 4'b0000);
      check("t3_release", btn_release, (e == 42) ? 4'b0010 : (e == 46) ? 4'b0001 : 4'b0000);
      check("t3_level", btn_level, (e < 42) ? 4'b0011 : (e < 46) ? 4'b0001 : 4'b0000);
    end

    // 4. All four channels pressed together
    btn_raw = 4'b1111;
    goto(55);
    check("t4_press_early", btn_press, 4'b0000);
    check("t4_any_early", btn_any, 1'b0);
    goto(56);
    check("t4_press", btn_press, 4'b1111);
    check("t4_any", btn_any, 1'b1);
    check("t4_level", btn_level, 4'b1111);
    goto(57);
    check("t4_press_end", btn_press, 4'b0000);
    check("t4_any_end", btn_any, 1'b0);
    goto(58);
    btn_raw = 4'b0000;
    goto(64);
    check("t4_release", btn_release, 4'b1111);
    check("t4_level_low", btn_level, 4'b0000);

    // 5. Auto-repeat on channel 2: press at 76, repeats at 86, 89, 92, ...
    goto(70);
    btn_raw[2] = 1'b1;
    goto(76);
    check("t5_press", btn_press, 4'b0100);
    check("t5_no_rpt_on_press", btn_repeat, 4'b0000);
    for (int e = 77; e <= 104; e++) begin
      logic exp_rpt;
      goto(e);
      exp_rpt = AR && (e == 86 || e == 89 || e == 92 || e == 95 || e == 98);
      check("t5_repeat", btn_repeat, {1'b0, exp_rpt, 2'b00});
      check("t5_any", btn_any, exp_rpt);
      check("t5_release", btn_release, (e == 99) ? 4'b0100 : 4'b0000);
      check("t5_level", btn_level[2], (e < 99) ? 1'b1 : 1'b0);
      if (e == 93) btn_raw[2] = 1'b0;
    end

    // 6. Reset while channel 0 is held
    goto(110);
    btn_raw[0] = 1'b1;
    goto(116);
    check("t6_press", btn_press, 4'b0001);
    goto(120);
    check("t6_held", btn_level, 4'b0001);
    reset = 1'b1;
    goto(121);
    check("t6_rst_level", btn_level, 4'b0000);
    check("t6_rst_release", btn_release, 4'b0000);
    check("t6_rst_press", btn_press, 4'b0000);
    check("t6_rst_any", btn_any, 1'b0);
    reset = 1'b0;
    for (int e = 122; e <= 128; e++) begin
      goto(e);
      check("t6_press_after", btn_press, (e == 127) ? 4'b0001 : 4'b0000);
      check("t6_release_after", btn_release, 4'b0000);
      check("t6_level_after", btn_level, (e >= 127) ? 4'b0001 : 4'b0000);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
